// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RISC-V load/store funct3
// encodings, the responder FSM state type and a funct3 legality helper.
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Stores only have sb/sh/sw; loads additionally have the unsigned forms.
    function automatic logic f3_is_legal(input logic is_write, input logic [2:0] f3);
        logic legal;
        if (is_write) begin
            legal = (f3 <= F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/lane_align.sv
// ---------------------------------------------------------------------------
// lane_align
// Combinational byte-lane steering for the data-memory responder.
// Store side: funct3 + addr[1:0] + unshifted store data -> byte enables,
// lane-replicated write data and a misalignment flag.
// Load side: raw RAM word -> lane-selected, sign/zero-extended load data.
// Ports:
//   req_write  in   1   1 = store (selects funct3 legality rule)
//   funct3     in   3   load/store size and signedness
//   addr_lo    in   2   byte offset within the word
//   wdata      in   32  store data, low byte/half significant
//   rword      in   32  word read from RAM
//   byte_en    out  4   per-lane write enables
//   lane_wdata out  32  store data replicated into every candidate lane
//   misalign   out  1   half not on 2-byte or word not on 4-byte boundary
//   bad_funct3 out  1   funct3 not a legal encoding for this direction
//   load_data  out  32  extended load result
// ---------------------------------------------------------------------------
module lane_align
    import dmem_pkg::*;
(
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic        misalign,
    output logic        bad_funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Size comes from funct3[1:0]; replicating the data means the byte
    // enables alone decide which lane actually gets written.
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = wdata;
        misalign   = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                misalign   = (addr_lo != 2'b00);
            end
            default: begin
                byte_en    = 4'b0000;
            end
        endcase
    end

    assign bad_funct3 = ~f3_is_legal(req_write, funct3);

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rword >> {addr_lo, 3'b000};

    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rword;
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Slave end of the RV32 core's load/store bus. Accepts one request at a time
// over valid/ready, commits stores with byte lanes, returns aligned and
// extended load data after a fixed latency, and flags misaligned, illegal
// funct3 or out-of-range requests.
// Parameters:
//   DEPTH    storage size in 32-bit words (power of 2)
//   LATENCY  cycles from the accepting request cycle to resp_valid (>= 1)
// Ports:
//   clk         in   1   single clock, rising edge
//   reset       in   1   asynchronous, active-low
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept (IDLE only)
//   req_write   in   1   1 = store, 0 = load
//   req_funct3  in   3   RISC-V load/store funct3
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, unshifted
//   resp_valid  out  1   response present, held until resp_ready
//   resp_ready  in   1   core takes the response
//   resp_rdata  out  32  extended load data, 0 for stores and errors
//   resp_err    out  1   request rejected
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 2) ? (LATENCY - 2) : 0);

    dmem_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        lat_write_q, lat_write_d;
    logic [2:0]  lat_funct3_q, lat_funct3_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    logic        acc_write;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [31:0] acc_rword;
    logic        acc_range_err;
    logic        acc_err;
    logic [3:0]  byte_en;
    logic [31:0] lane_wdata;
    logic        misalign;
    logic        bad_funct3;
    logic [31:0] load_data;
    logic        mem_we;
    logic        accept;

    assign accept = req_valid & ready_q;

    // The RAM access happens on the edge entering RESP. With LATENCY=1 that
    // is the accept edge itself, so the live request is used while IDLE;
    // otherwise the latched copy is used from WAIT.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write  = req_write;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = lat_write_q;
            acc_funct3 = lat_funct3_q;
            acc_addr   = lat_addr_q;
            acc_wdata  = lat_wdata_q;
        end
    end

    assign acc_idx       = acc_addr[AW+1:2];
    assign acc_rword     = mem[acc_idx];
    assign acc_range_err = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    assign acc_err       = misalign | bad_funct3 | acc_range_err;

    lane_align u_lane_align (
        .req_write  (acc_write),
        .funct3     (acc_funct3),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .rword      (acc_rword),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .misalign   (misalign),
        .bad_funct3 (bad_funct3),
        .load_data  (load_data)
    );

    // Next-state and response computation. Entering RESP loads the whole
    // response at once; the response registers then hold until resp_ready,
    // and resp_ready outside RESP falls through the default and is ignored.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        lat_write_d  = lat_write_q;
        lat_funct3_d = lat_funct3_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d      = 1'b0;
                    lat_write_d  = req_write;
                    lat_funct3_d = req_funct3;
                    lat_addr_d   = req_addr;
                    lat_wdata_d  = req_wdata;
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = acc_err;
                        resp_rdata_d = (acc_err | acc_write) ? 32'h0 : load_data;
                        mem_we       = acc_write & ~acc_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                ready_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err | acc_write) ? 32'h0 : load_data;
                    mem_we       = acc_write & ~acc_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                ready_d = 1'b0;
                if (resp_ready) begin
                    state_d      = IDLE;
                    ready_d      = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // All control and response state; reset drops any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            lat_write_q  <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_addr_q   <= 32'h0;
            lat_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            lat_write_q  <= lat_write_d;
            lat_funct3_q <= lat_funct3_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is deliberately not reset; a store only lands when the FSM
    // actually enters RESP, so a reset during WAIT leaves the RAM untouched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[acc_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance driven from a vector
// table, and a LATENCY=3 instance for back-pressure and reset-in-flight cases.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_req_valid, a_req_ready, a_req_write;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    logic        b_reset, b_req_valid, b_req_ready, b_req_write;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    int tests = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    typedef struct {
        bit          write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        bit          expErr;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit write, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expData,
                          input bit expErr, input string name);
        vec_t v;
        v.write = write; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.expData = expData; v.expErr = expErr; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on the selected instance: wait for ready, present
    // the request for one edge, count edges to resp_valid, then acknowledge.
    task automatic applyStimulus(input bit sel, input bit write, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? b_req_ready : a_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_timeout", 32'(n >= 20), 32'd0);
        if (sel) begin
            b_req_valid = 1'b1; b_req_write = write; b_req_funct3 = f3;
            b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = 1'b1; a_req_write = write; a_req_funct3 = f3;
            a_req_addr = addr; a_req_wdata = wdata;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!(sel ? b_resp_valid : a_resp_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = sel ? b_resp_rdata : a_resp_rdata;
        err   = sel ? b_resp_err : a_resp_err;
        if (sel) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;

        a_req_valid = 0; a_req_write = 0; a_req_funct3 = 0; a_req_addr = 0;
        a_req_wdata = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_funct3 = 0; b_req_addr = 0;
        b_req_wdata = 0; b_resp_ready = 0;
        a_reset = 1'b1; b_reset = 1'b1;
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(a_req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", a_resp_rdata, 32'h0);
        checkOutput("rst_resp_err", 32'(a_resp_err), 32'd0);
        repeat (3) @(posedge clk);
        checkOutput("rst_req_ready_held", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        a_reset = 1'b1; b_reset = 1'b1;

        addVec(1, 3'b010, 32'h64, 32'hDEADBEEF, 32'h0, 0, "sw_64");
        addVec(0, 3'b010, 32'h64, 32'h0, 32'hDEADBEEF, 0, "lw_64");
        addVec(1, 3'b010, 32'h60, 32'h0, 32'h0, 0, "sw_60");
        addVec(1, 3'b000, 32'h61, 32'h80, 32'h0, 0, "sb_61");
        addVec(0, 3'b000, 32'h61, 32'h0, 32'hFFFFFF80, 0, "lb_61");
        addVec(0, 3'b100, 32'h61, 32'h0, 32'h00000080, 0, "lbu_61");
        addVec(0, 3'b010, 32'h60, 32'h0, 32'h00008000, 0, "lw_60_a");
        addVec(1, 3'b001, 32'h62, 32'h1234ABCD, 32'h0, 0, "sh_62");
        addVec(0, 3'b010, 32'h60, 32'h0, 32'hABCD8000, 0, "lw_60_b");
        addVec(0, 3'b001, 32'h62, 32'h0, 32'hFFFFABCD, 0, "lh_62");
        addVec(0, 3'b101, 32'h62, 32'h0, 32'h0000ABCD, 0, "lhu_62");
        addVec(0, 3'b010, 32'h66, 32'h0, 32'h0, 1, "lw_mis_66");
        addVec(1, 3'b001, 32'h63, 32'h5555, 32'h0, 1, "sh_mis_63");
        addVec(0, 3'b011, 32'h60, 32'h0, 32'h0, 1, "ld_f3_011");
        addVec(0, 3'b010, 32'h400, 32'h0, 32'h0, 1, "lw_range_400");
        addVec(1, 3'b100, 32'h60, 32'hFFFFFFFF, 32'h0, 1, "st_f3_100");
        addVec(0, 3'b010, 32'h60, 32'h0, 32'hABCD8000, 0, "lw_60_c");
        addVec(1, 3'b010, 32'h0, 32'h11111111, 32'h0, 0, "sw_0");
        addVec(1, 3'b010, 32'h400, 32'h22222222, 32'h0, 1, "sw_range_400");
        addVec(0, 3'b010, 32'h0, 32'h0, 32'h11111111, 0, "lw_0");
        addVec(1, 3'b000, 32'h3, 32'h000000A5, 32'h0, 0, "sb_3");
        addVec(0, 3'b010, 32'h0, 32'h0, 32'hA5111111, 0, "lw_0_b");
        addVec(0, 3'b000, 32'h3, 32'h0, 32'hFFFFFFA5, 0, "lb_3");

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          rdata, err, lat);
            checkOutput({vecs[i].name, "_rdata"}, rdata, vecs[i].expData);
            checkOutput({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].expErr));
            checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
        end

        // LATENCY=3: plain store/load round trip with latency check.
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h70, 32'hCAFEF00D, rdata, err, lat);
        checkOutput("l3_sw_lat", 32'(lat), 32'd3);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h70, 32'h0, rdata, err, lat);
        checkOutput("l3_lw_rdata", rdata, 32'hCAFEF00D);
        checkOutput("l3_lw_lat", 32'(lat), 32'd3);

        // Back-pressure: response must hold while resp_ready stays low.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_funct3 = 3'b101; b_req_addr = 32'h72;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!b_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_lat", 32'(lat), 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_valid_hold", 32'(b_resp_valid), 32'd1);
            checkOutput("bp_rdata_hold", b_resp_rdata, 32'h0000CAFE);
            checkOutput("bp_err_hold", 32'(b_resp_err), 32'd0);
            checkOutput("bp_req_ready_low", 32'(b_req_ready), 32'd0);
        end
        b_resp_ready = 1'b1;
        @(posedge clk);
        #1 b_resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(b_resp_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(b_req_ready), 32'd1);

        // Reset during WAIT: in-flight store must not land.
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_funct3 = 3'b010;
        b_req_addr = 32'h70; b_req_wdata = 32'h55;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("wait_valid_low", 32'(b_resp_valid), 32'd0);
        b_reset = 1'b0;
        #1;
        checkOutput("rst_wait_ready", 32'(b_req_ready), 32'd0);
        checkOutput("rst_wait_valid", 32'(b_resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        b_reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h70, 32'h0, rdata, err, lat);
        checkOutput("after_rst_lw_rdata", rdata, 32'hCAFEF00D);
        checkOutput("after_rst_lw_err", 32'(err), 32'd0);

        // Reset while a response is held must clear it without a clock edge.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h70;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("hold_before_rst_valid", 32'(b_resp_valid), 32'd1);
        checkOutput("hold_before_rst_rdata", b_resp_rdata, 32'hCAFEF00D);
        #2 b_reset = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(b_resp_valid), 32'd0);
        checkOutput("async_rst_rdata", b_resp_rdata, 32'h0);
        checkOutput("async_rst_err", 32'(b_resp_err), 32'd0);
        @(negedge clk);
        b_reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
